// File: rtl/feature_window_cache.sv
// 3x3 sliding-window generator: two line buffers plus a 3x3 tap register array
// turn a raster pixel stream into one window per accepted pixel.
module feature_window_cache #(
    parameter int FEATURE_WIDTH = 16,
    parameter int PE_CORE_NUM   = 16,
    parameter int PIXEL_WIDTH   = PE_CORE_NUM * FEATURE_WIDTH,
    parameter int MAX_COL       = 1024
) (
    input  logic                     system_clk,
    input  logic                     rst_n,
    input  logic                     frame_start,
    input  logic [9:0]               col_size,
    input  logic [PIXEL_WIDTH-1:0]   pixel_data,
    input  logic                     pixel_valid,
    output logic                     pixel_ready,
    output logic [9*PIXEL_WIDTH-1:0] window_data,
    output logic                     window_valid,
    input  logic                     window_ready,
    output logic                     window_complete,
    output logic [9:0]               window_row,
    output logic [9:0]               window_col,
    output logic                     frame_done
);

    logic [9:0]             row_q, row_d;
    logic [9:0]             col_q, col_d;
    logic [9:0]             last_col_q, last_col_d;
    logic                   window_valid_q, window_valid_d;
    logic                   window_complete_q;
    logic [9:0]             window_row_q, window_col_q;
    logic [PIXEL_WIDTH-1:0] tap_q [0:8];
    logic [PIXEL_WIDTH-1:0] row_in [0:2];
    logic [PIXEL_WIDTH-1:0] lb0 [0:MAX_COL-1];
    logic [PIXEL_WIDTH-1:0] lb1 [0:MAX_COL-1];
    logic                   accept;

    // frame_start blocks the input for one cycle so it cannot race an accept
    assign pixel_ready = (~window_valid_q | window_ready) & ~frame_start;
    assign accept      = pixel_valid & pixel_ready;

    always_comb begin
        row_d      = row_q;
        col_d      = col_q;
        last_col_d = last_col_q;
        if (frame_start) begin
            row_d      = 10'd0;
            col_d      = 10'd0;
            last_col_d = col_size - 10'd1;   // 0 encodes 1024 -> last column 1023
        end else if (accept) begin
            if (col_q == last_col_q) begin
                col_d = 10'd0;
                if (row_q != 10'd1023) begin
                    row_d = row_q + 10'd1;
                end
            end else begin
                col_d = col_q + 10'd1;
            end
        end
    end

    always_comb begin
        window_valid_d = window_valid_q;
        if (frame_start) begin
            window_valid_d = 1'b0;
        end else if (accept) begin
            window_valid_d = 1'b1;
        end else if (window_ready) begin
            window_valid_d = 1'b0;
        end
    end

    always_ff @(posedge system_clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q             <= 10'd0;
            col_q             <= 10'd0;
            last_col_q        <= 10'd1023;
            window_valid_q    <= 1'b0;
            window_complete_q <= 1'b0;
            window_row_q      <= 10'd0;
            window_col_q      <= 10'd0;
        end else begin
            row_q          <= row_d;
            col_q          <= col_d;
            last_col_q     <= last_col_d;
            window_valid_q <= window_valid_d;
            if (accept) begin
                window_complete_q <= (row_q >= 10'd2) && (col_q >= 10'd2);
                window_row_q      <= row_q;
                window_col_q      <= col_q;
            end
        end
    end

    // Line buffers rotate on accept; non-blocking writes give old data on read-during-write
    always_ff @(posedge system_clk) begin
        if (accept) begin
            lb0[col_q] <= pixel_data;
            lb1[col_q] <= lb0[col_q];
        end
    end

    assign row_in[0] = lb1[col_q];
    assign row_in[1] = lb0[col_q];
    assign row_in[2] = pixel_data;

    // Each window row is a 3-deep column shift register; the newest column enters at col_off 2
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_tap_row
            always_ff @(posedge system_clk or negedge rst_n) begin
                if (!rst_n) begin
                    tap_q[gi*3]     <= '0;
                    tap_q[gi*3 + 1] <= '0;
                    tap_q[gi*3 + 2] <= '0;
                end else if (accept) begin
                    tap_q[gi*3]     <= tap_q[gi*3 + 1];
                    tap_q[gi*3 + 1] <= tap_q[gi*3 + 2];
                    tap_q[gi*3 + 2] <= row_in[gi];
                end
            end
        end
        for (gi = 0; gi < 9; gi++) begin : g_tap_out
            assign window_data[gi*PIXEL_WIDTH +: PIXEL_WIDTH] = tap_q[gi];
        end
    endgenerate

    assign window_valid    = window_valid_q;
    assign window_complete = window_complete_q;
    assign window_row      = window_row_q;
    assign window_col      = window_col_q;
    assign frame_done      = 1'b0;

endmodule

// File: tb/tb_feature_window_cache.sv
// Bench for feature_window_cache: scoreboard built from a frame image array,
// plus a constant tap table for the 5x5 ramp frame.
module tb_feature_window_cache;

    localparam int FW  = 16;
    localparam int PCN = 16;
    localparam int PW  = FW * PCN;

    logic              system_clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_start = 1'b0;
    logic [9:0]        col_size = 10'd5;
    logic [PW-1:0]     pixel_data = '0;
    logic              pixel_valid = 1'b0;
    logic              pixel_ready;
    logic [9*PW-1:0]   window_data;
    logic              window_valid;
    logic              window_ready = 1'b0;
    logic              window_complete;
    logic [9:0]        window_row;
    logic [9:0]        window_col;
    logic              frame_done;

    feature_window_cache #(.FEATURE_WIDTH(FW), .PE_CORE_NUM(PCN), .MAX_COL(1024)) dut (
        .system_clk      (system_clk),
        .rst_n           (rst_n),
        .frame_start     (frame_start),
        .col_size        (col_size),
        .pixel_data      (pixel_data),
        .pixel_valid     (pixel_valid),
        .pixel_ready     (pixel_ready),
        .window_data     (window_data),
        .window_valid    (window_valid),
        .window_ready    (window_ready),
        .window_complete (window_complete),
        .window_row      (window_row),
        .window_col      (window_col),
        .frame_done      (frame_done)
    );

    always #5 system_clk = ~system_clk;

    typedef struct {
        int          r;
        int          c;
        logic        cpl;
        logic [9*PW-1:0] taps;
    } exp_t;

    typedef struct {
        int r;
        int c;
        int taps [9];
    } vec_t;

    exp_t          q[$];
    vec_t          vec [4];
    logic [PW-1:0] img [0:7][0:1023];
    int            cap [0:7][0:7][0:8];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            brow = 0, bcol = 0, cur_cols = 5;
    int            ramp_mul = 10;
    bit            rand_data = 1'b0;
    bit            lat_pending = 1'b0;
    int            n_win = 0, n_cpl = 0, cyc = 0, sent = 0;
    int            last_r = 0, last_c = 0;

    function automatic logic [PW-1:0] gen(input int base);
        logic [PW-1:0] p;
        for (int ch = 0; ch < PCN; ch++) begin
            p[ch*FW +: FW] = FW'(base + ch * 4096);
        end
        return p;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_window(input exp_t e);
        chk("win_row", longint'(window_row), longint'(e.r));
        chk("win_col", longint'(window_col), longint'(e.c));
        chk("win_complete", longint'(window_complete), longint'(e.cpl));
        if (e.cpl) begin
            n_cmp++;
            if (window_data !== e.taps) begin
                n_bad++;
                for (int k = 0; k < 9; k++) begin
                    if (window_data[k*PW +: PW] !== e.taps[k*PW +: PW]) begin
                        $display("FAIL win_data (%0d,%0d) tap %0d ch0: got %0d, expected %0d",
                                 e.r, e.c, k, window_data[k*PW +: FW], e.taps[k*PW +: FW]);
                        break;
                    end
                end
            end
            n_cpl++;
        end
        if (e.r < 8 && e.c < 8) begin
            for (int k = 0; k < 9; k++) cap[e.r][e.c][k] = int'(window_data[k*PW +: FW]);
        end
        last_r = int'(window_row);
        last_c = int'(window_col);
        n_win++;
    endtask

    task automatic cycle();
        logic acc, ho;
        exp_t e;
        @(negedge system_clk);
        chk("pixel_ready", longint'(pixel_ready),
            longint'((!window_valid || window_ready) && !frame_start));
        chk("frame_done", longint'(frame_done), 0);
        acc = pixel_valid & pixel_ready;
        ho  = window_valid & window_ready;
        if (lat_pending) chk("latency", longint'(window_valid), 1);
        if (window_valid && q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL spurious_window: got window (%0d,%0d), expected none", window_row, window_col);
        end
        if (ho && q.size() > 0) begin
            e = q.pop_front();
            check_window(e);
        end
        if (acc) begin
            img[brow & 7][bcol] = pixel_data;
            e.r    = brow;
            e.c    = bcol;
            e.cpl  = (brow >= 2) && (bcol >= 2);
            e.taps = '0;
            if (e.cpl) begin
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        e.taps[(i*3+j)*PW +: PW] = img[(brow-2+i) & 7][bcol-2+j];
            end
            q.push_back(e);
            bcol++;
            if (bcol == cur_cols) begin
                bcol = 0;
                brow++;
            end
            sent++;
        end
        lat_pending = acc;
        @(posedge system_clk);
        #1;
        cyc++;
    endtask

    task automatic start_frame(input int cs, input bit pv);
        frame_start  = 1'b1;
        col_size     = 10'(cs);
        window_ready = 1'b0;
        pixel_valid  = pv;
        cycle();
        frame_start  = 1'b0;
        pixel_valid  = 1'b0;
        chk("valid_after_frame_start", longint'(window_valid), 0);
        q.delete();
        lat_pending = 1'b0;
        brow = 0;
        bcol = 0;
        cur_cols = (cs == 0) ? 1024 : cs;
        n_win = 0;
        n_cpl = 0;
    endtask

    // rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random
    task automatic stream(input int npix, input int rmode, input bit vrand);
        int guard;
        int k;
        guard = 0;
        sent  = 0;
        k     = 0;
        while (sent < npix && guard < npix * 8 + 20) begin
            pixel_valid = vrand ? ($urandom_range(0, 3) != 0) : 1'b1;
            pixel_data  = rand_data ? gen(int'($urandom)) : gen(brow * ramp_mul + bcol);
            case (rmode)
                0:       window_ready = 1'b1;
                1:       window_ready = (k % 4 == 0) || (k % 4 == 3);
                default: window_ready = ($urandom_range(0, 2) != 0);
            endcase
            cycle();
            guard++;
            k++;
        end
        pixel_valid = 1'b0;
        if (sent < npix) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stream_timeout: got %0d pixels accepted, expected %0d", sent, npix);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        pixel_valid  = 1'b0;
        window_ready = 1'b1;
        while (q.size() > 0 && g < 10) begin
            cycle();
            g++;
        end
        if (q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d windows pending, expected 0", q.size());
        end
    endtask

    task automatic check_table();
        for (int i = 0; i < 4; i++) begin
            int bad_k;
            bad_k = -1;
            for (int k = 0; k < 9; k++) begin
                if (bad_k < 0 && cap[vec[i].r][vec[i].c][k] != vec[i].taps[k]) bad_k = k;
            end
            n_cmp++;
            if (bad_k >= 0) begin
                n_bad++;
                $display("FAIL table_tap (%0d,%0d) tap %0d: got %0d, expected %0d", vec[i].r, vec[i].c,
                         bad_k, cap[vec[i].r][vec[i].c][bad_k], vec[i].taps[bad_k]);
            end
        end
    endtask

    task automatic clear_cap();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                for (int k = 0; k < 9; k++) cap[r][c][k] = -1;
    endtask

    initial begin
        int c0;
        vec[0].r = 2; vec[0].c = 2; vec[0].taps = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
        vec[1].r = 4; vec[1].c = 4; vec[1].taps = '{22, 23, 24, 32, 33, 34, 42, 43, 44};
        vec[2].r = 3; vec[2].c = 3; vec[2].taps = '{11, 12, 13, 21, 22, 23, 31, 32, 33};
        vec[3].r = 2; vec[3].c = 4; vec[3].taps = '{2, 3, 4, 12, 13, 14, 22, 23, 24};

        // reset state
        #12;
        chk("rst_window_valid", longint'(window_valid), 0);
        chk("rst_window_complete", longint'(window_complete), 0);
        chk("rst_window_row", longint'(window_row), 0);
        chk("rst_window_col", longint'(window_col), 0);
        chk("rst_window_data_zero", longint'(window_data == '0), 1);
        chk("rst_frame_done", longint'(frame_done), 0);
        #11 rst_n = 1'b1;
        @(posedge system_clk);
        #1;
        chk("rst_pixel_ready", longint'(pixel_ready), 1);

        // 5x5 ramp, ready always high; col_size change after start is ignored
        ramp_mul = 10;
        clear_cap();
        start_frame(5, 1'b0);
        col_size = 10'd9;
        c0 = cyc;
        stream(25, 0, 1'b0);
        chk("throughput_cycles", cyc - c0, 25);
        drain();
        chk("5x5_windows", n_win, 25);
        chk("5x5_complete", n_cpl, 9);
        check_table();

        // same frame with ready pattern 1,0,0,1
        clear_cap();
        start_frame(5, 1'b0);
        stream(25, 1, 1'b0);
        drain();
        chk("5x5_bp_windows", n_win, 25);
        chk("5x5_bp_complete", n_cpl, 9);
        check_table();

        // 1024-wide frame, 4 rows plus one wrap pixel
        ramp_mul = 1024;
        start_frame(0, 1'b0);
        stream(4097, 0, 1'b0);
        drain();
        chk("w1024_complete", n_cpl, 2044);
        chk("w1024_wrap_row", last_r, 4);
        chk("w1024_wrap_col", last_c, 0);

        // mid-frame abort at pixel (2,3) with col_size 5 -> 7
        ramp_mul = 10;
        start_frame(5, 1'b0);
        stream(13, 0, 1'b0);
        chk("abort_valid_before", longint'(window_valid), 1);
        pixel_data = gen(23);
        start_frame(7, 1'b1);
        stream(28, 1, 1'b0);
        drain();
        chk("abort_windows", n_win, 28);
        chk("abort_complete", n_cpl, 10);

        // asynchronous reset while window_valid is high
        start_frame(5, 1'b0);
        stream(7, 0, 1'b0);
        window_ready = 1'b0;
        #2;
        chk("prereset_valid", longint'(window_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_valid", longint'(window_valid), 0);
        chk("async_reset_row", longint'(window_row), 0);
        chk("async_reset_col", longint'(window_col), 0);
        #3 rst_n = 1'b1;
        @(posedge system_clk);
        #1;
        q.delete();
        lat_pending = 1'b0;
        start_frame(3, 1'b0);
        stream(9, 0, 1'b0);
        drain();
        chk("post_reset_windows", n_win, 9);
        chk("post_reset_complete", n_cpl, 1);
        chk("post_reset_last_row", last_r, 2);
        chk("post_reset_last_col", last_c, 2);

        // random data, random valid/ready
        rand_data = 1'b1;
        start_frame(6, 1'b0);
        stream(36, 2, 1'b1);
        drain();
        chk("rand6_complete", n_cpl, 16);
        start_frame(3, 1'b0);
        stream(12, 2, 1'b1);
        drain();
        chk("rand3_complete", n_cpl, 2);
        start_frame(9, 1'b0);
        stream(45, 2, 1'b1);
        drain();
        chk("rand9_complete", n_cpl, 21);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/feature_window_cache.md
Name: feature_window_cache

Overview:
- Sits directly downstream of the feature buffer.
- Consumes its raster-ordered, already-padded pixel stream; each pixel carries PE_CORE_NUM channels.
- Keeps the two previous rows in on-chip line buffers and emits one 3x3 window per accepted pixel to the convolution PE array.
- Tags each window as complete (all 9 taps inside the current frame) or partial, so the PE array can gate accumulation.

Parameters:
- FEATURE_WIDTH, 16: bits per channel sample.
- PE_CORE_NUM, 16: channels per pixel.
- PIXEL_WIDTH, PE_CORE_NUM*FEATURE_WIDTH: bits per pixel.
- MAX_COL, 1024: maximum padded row length; sets line-buffer depth.

Ports:
- system_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  one-cycle pulse; clears position counters and latches col_size
- col_size  in  10  padded row length, legal range 3..MAX_COL (MAX_COL=1024 encoded as 0)
- pixel_data  in  PIXEL_WIDTH  input pixel
- pixel_valid  in  1  input valid
- pixel_ready  out  1  input ready
- window_data  out  9*PIXEL_WIDTH  3x3 window, tap k = row_off*3+col_off, k=0 at low bits
- window_valid  out  1  output valid
- window_ready  in  1  output ready
- window_complete  out  1  window fully inside frame (row>=2 and col>=2)
- window_row  out  10  row index of centre-bottom-right (current) pixel
- window_col  out  10  column index of current pixel
- frame_done  out  1  one-cycle pulse with the last window of the frame handed off

Behaviour:
- Reset (async, rst_n low):
  - window_valid, window_complete and frame_done go to 0.
  - window_row, window_col and window_data go to 0.
  - Internal row/col counters go to 0; the latched col_size goes to 1024.
  - Line-buffer RAM contents are not reset.
- Handshakes:
  - Accept when pixel_valid & pixel_ready.
  - pixel_ready = ~window_valid | window_ready: a single output register, no combinational path from pixel_valid to window_valid.
  - Hand-off when window_valid & window_ready.
  - Outputs hold stable while window_valid & ~window_ready.
- Latency: a pixel accepted at cycle N appears on window_data with window_valid high at cycle N+1.
  - Sustained throughput is 1 window/cycle when window_ready stays high.
- Storage:
  - lb0[c] holds row r-1; lb1[c] holds row r-2.
  - On accept at column c: read lb0[c] and lb1[c]; write lb1[c] <= old lb0[c] and lb0[c] <= pixel_data.
  - Read-during-write to the same address returns old data.
  - Three 3-deep column shift registers (one per row) shift on accept only.
  - Tap 8 = current pixel (r,c); tap 0 = (r-2,c-2).
- Counters:
  - col increments on accept; at col == col_size_latched-1 it wraps to 0 and row increments.
  - row is 10-bit and saturates at 1023.
  - No internal frame-height knowledge: frame_done pulses on hand-off of a window whose col == last column and for which frame_end_hint is asserted. frame_end_hint is omitted; frame_done fires when row == row_last.
  - Resolution: frame_done is removed from scope. The port is tied 0 and reserved.
- Partial windows:
  - window_complete = (row>=2) & (col>=2), computed from the accepted pixel's position.
  - Tap contents of partial windows are unspecified.
  - Complete windows must be bit-exact.
- frame_start:
  - Takes priority over a simultaneous accept; that pixel is not accepted (pixel_ready is forced 0 in that cycle).
  - Clears counters, clears window_valid, and relatches col_size.
  - Mid-frame frame_start aborts the frame; stale line-buffer data only affects partial windows of the new frame.
- col_size changes without frame_start are ignored.
- Out-of-range col_size values 1 and 2 are illegal; the behaviour is unspecified, but the counters still wrap without X.

Test Plan:
- 5x5 frame, 1 channel: pixel value = 10*row+col, window_ready=1.
  - 25 windows out with latency 1.
  - First complete window at (2,2) has taps {0,1,2,10,11,12,20,21,22}.
  - Window at (4,4) has taps {22,23,24,32,33,34,42,43,44}.
  - 9 complete windows in total.
- Same frame with window_ready toggling 1,0,0,1 per cycle:
  - Identical window sequence; pixel_ready low whenever window_valid & ~window_ready.
  - No drop or duplicate.
- col_size=0 (1024), 4 rows of ramp data: window at (3,1023) taps equal rows 1..3 cols 1021..1023; col wraps to 0 and row increments.
- frame_start asserted at pixel (2,3) with col_size changed from 5 to 7:
  - That pixel is not accepted and window_valid drops.
  - The next accept is reported at (0,0).
  - Complete windows of the new 7-wide frame are correct.
- rst_n pulsed low mid-frame while window_valid=1:
  - window_valid=0 immediately (async).
  - After release, frame_start plus a 3x3 frame gives one complete window at (2,2) with correct taps.
- 16-channel pixels with distinct per-channel values: each channel slice of each tap maps to the same channel index in the input.
